pga_autocal: RTL and testbench

PGA_AUTOCAL -- requirements
Module: pga_autocal

---
 rtl/pga_autocal_if.sv | 33 +++
 rtl/pga_autocal.sv | 229 ++++++++++++++++++++++
 tb/tb_pga_autocal.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pga_autocal_if.sv
// ---------------------------------------------------------------------------
// pga_autocal_if -- command bus between the auto-calibration sequencer and
// the downstream PGA serial controller.
//
// Signals
//   set_measure, set_vos, set_gain  command strobes (sequencer -> controller)
//   offset [4:0]                    offset value accompanying set_vos
//   gain   [3:0]                    gain value accompanying set_gain
//   op_complete                     completion level (controller -> sequencer),
//                                   asynchronous to the sequencer clock
//
// Modports
//   master  the sequencer (drives strobes and data, reads op_complete)
//   slave   the serial controller
// ---------------------------------------------------------------------------
interface pga_autocal_if;
  logic       set_measure;
  logic       set_vos;
  logic       set_gain;
  logic [4:0] offset;
  logic [3:0] gain;
  logic       op_complete;

  modport master (
    output set_measure, set_vos, set_gain, offset, gain,
    input  op_complete
  );

  modport slave (
    input  set_measure, set_vos, set_gain, offset, gain,
    output op_complete
  );
endinterface

// File: rtl/pga_autocal.sv
// ---------------------------------------------------------------------------
// pga_autocal -- PGA input-offset auto-calibration sequencer.
//
// On an accepted start the block issues set_measure, resolves a 5-bit offset
// by successive approximation (MSB first, one set_vos trial per bit, settle,
// then sample the comparator), writes the resolved offset with a final
// set_vos, applies the gain latched at start with set_gain, and pulses done.
// Every command uses a four-phase handshake against op_complete.
//
// Parameters
//   SETTLE_CYCLES   clk50 cycles waited after each trial write before sampling
//   TIMEOUT_CYCLES  clk50 cycles allowed per command handshake
//
// Ports
//   clk50        system clock
//   wb_rst       asynchronous active-high reset
//   start        one-cycle calibration request (accepted only when idle)
//   gain_in      gain to apply after calibration, latched on accepted start
//   cmp_in       asynchronous comparator; 1 = trial offset not too high
//   pga          command bus to the PGA serial controller (master side)
//   busy         high from start acceptance until done or error
//   done         one-cycle pulse on successful completion
//   error        sticky timeout flag, cleared by the next accepted start
//   cal_offset   calibrated offset, updated as done pulses
//
// Configuration
//   PGA_AUTOCAL_TIMEOUT_EN  when defined, a handshake wait lasting
//                           TIMEOUT_CYCLES aborts the run through ERR and sets
//                           error. When undefined, waits are unbounded and
//                           error stays 0.
// ---------------------------------------------------------------------------
module pga_autocal #(
  parameter int SETTLE_CYCLES  = 250,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk50,
  input  logic                 wb_rst,
  input  logic                 start,
  input  logic [3:0]           gain_in,
  input  logic                 cmp_in,
  pga_autocal_if.master        pga,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [4:0]           cal_offset
);

  // One counter serves both the settle delay and the handshake timeout; the
  // two never run at the same time.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef PGA_AUTOCAL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, MEAS, TRIAL, SETTLE, SAMPLE, FINAL, GAIN, DONE, ERR
  } state_t;

  // HOLD: strobe high, waiting for op_complete=1.
  // RELEASE: strobe low, waiting for op_complete=0.
  typedef enum logic {PH_HOLD, PH_RELEASE} phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [1:0]       cmp_sync, opc_sync;
  logic             cmp_s, opc_s;
  logic [CNT_W-1:0] cnt;
  logic             count_en;
  logic             cmd_state;
  logic [4:0]       trial;
  logic [2:0]       idx;
  logic [4:0]       offset_r;
  logic [3:0]       gain_r;
  logic             error_r;
  logic [4:0]       bit_now, bit_next, trial_new;

  // -------------------------------------------------------------------------
  // Input synchronizers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk50 or posedge wb_rst) begin
    if (wb_rst) begin
      cmp_sync <= 2'b00;
      opc_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous
      // stage's old value; blocking ones would collapse the two-flop chain.
      cmp_sync <= {cmp_sync[0], cmp_in};
      opc_sync <= {opc_sync[0], pga.op_complete};
    end
  end

  assign cmp_s = cmp_sync[1];
  assign opc_s = opc_sync[1];

  assign cmd_state = (state == MEAS) || (state == TRIAL) ||
                     (state == FINAL) || (state == GAIN);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk50 or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      phase <= PH_HOLD;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_n = state;
    phase_n = phase;

    if (cmd_state) begin
      if (phase == PH_HOLD) begin
        if (opc_s) phase_n = PH_RELEASE;
      end else if (!opc_s) begin
        // Handshake closed: controller has dropped op_complete again.
        phase_n = PH_HOLD;
        if (state == MEAS)       state_n = TRIAL;
        else if (state == TRIAL) state_n = SETTLE;
        else if (state == FINAL) state_n = GAIN;
        else                     state_n = DONE;
      end
    end else begin
      unique case (state)
        IDLE:    if (start) state_n = MEAS;
        SETTLE:  if (cnt == SETTLE_LAST) state_n = SAMPLE;
        SAMPLE:  state_n = (idx == 3'd0) ? FINAL : TRIAL;
        DONE:    state_n = IDLE;
        ERR:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

`ifdef PGA_AUTOCAL_TIMEOUT_EN
    // The counter spans both handshake phases of one command.
    if (cmd_state && (cnt == TIMEOUT_LAST)) begin
      state_n = ERR;
      phase_n = PH_HOLD;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Settle / timeout counter: cleared on every state change, so it restarts
  // at each strobe rise and at SETTLE entry.
  // -------------------------------------------------------------------------
`ifdef PGA_AUTOCAL_TIMEOUT_EN
  assign count_en = (state == SETTLE) || cmd_state;
`else
  assign count_en = (state == SETTLE);
`endif

  always_ff @(posedge clk50 or posedge wb_rst) begin
    if (wb_rst)                 cnt <= '0;
    else if (state_n != state)  cnt <= '0;
    else if (count_en)          cnt <= cnt + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Successive-approximation datapath
  // -------------------------------------------------------------------------
  assign bit_now   = 5'b00001 << idx;
  assign bit_next  = 5'b00001 << (idx - 3'd1);
  assign trial_new = cmp_s ? (trial | bit_now) : trial;

  always_ff @(posedge clk50 or posedge wb_rst) begin
    if (wb_rst) begin
      trial      <= '0;
      idx        <= '0;
      offset_r   <= '0;
      gain_r     <= '0;
      cal_offset <= '0;
      error_r    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        trial   <= '0;
        idx     <= 3'd4;
        gain_r  <= gain_in;
        error_r <= 1'b0;
      end

      // First trial value is set up before TRIAL is entered so offset is
      // already stable when set_vos rises.
      if (state == MEAS && state_n == TRIAL) offset_r <= 5'b10000;

      if (state == SAMPLE) begin
        trial <= trial_new;
        if (idx != 3'd0) begin
          idx      <= idx - 3'd1;
          offset_r <= trial_new | bit_next;
        end else begin
          offset_r <= trial_new;
        end
      end

      if (state == GAIN && state_n == DONE) cal_offset <= trial;

`ifdef PGA_AUTOCAL_TIMEOUT_EN
      if (state != ERR && state_n == ERR) error_r <= 1'b1;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Strobes decode from registered state, so at most one is high and all
  // drop the instant reset asserts.
  assign pga.set_measure = (state == MEAS)  && (phase == PH_HOLD);
  assign pga.set_vos     = ((state == TRIAL) || (state == FINAL)) && (phase == PH_HOLD);
  assign pga.set_gain    = (state == GAIN)  && (phase == PH_HOLD);
  assign pga.offset      = offset_r;
  assign pga.gain        = gain_r;

  assign busy  = cmd_state || (state == SETTLE) || (state == SAMPLE);
  assign done  = (state == DONE);
  assign error = error_r;

endmodule

// File: tb/tb_pga_autocal.sv
// ---------------------------------------------------------------------------
// tb_pga_autocal -- directed bench for pga_autocal.
// Comparator model: cmp_in = 1 iff offset <= 19 (or tied high/low).
// Controller model: op_complete rises 10 cycles after any strobe, falls once
// the strobe drops. Command log entries are {kind[2:0], value[4:0]} with
// kind 001=set_measure, 010=set_vos, 100=set_gain; the first eight entries
// pack MSB-first into a 64-bit signature.
// ---------------------------------------------------------------------------
module tb_pga_autocal;

  logic       clk50 = 1'b0;
  logic       wb_rst;
  logic       start;
  logic [3:0] gain_in;
  wire        cmp_in;
  logic       busy, done, error;
  logic [4:0] cal_offset;

  pga_autocal_if bus ();

  pga_autocal dut (
    .clk50      (clk50),
    .wb_rst     (wb_rst),
    .start      (start),
    .gain_in    (gain_in),
    .cmp_in     (cmp_in),
    .pga        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cal_offset (cal_offset)
  );

  always #5 clk50 = ~clk50;

  int         checks = 0;
  int         errors = 0;
  int         cmp_mode = 0;   // 0 threshold model, 1 tied high, 2 tied low
  bit         resp_en = 1'b1;
  logic [7:0] ev[$];
  int         done_cnt = 0;
  int         multi_hot = 0;

  assign cmp_in = (cmp_mode == 1) ? 1'b1 :
                  (cmp_mode == 2) ? 1'b0 : (bus.offset <= 5'd19);

  // Controller model
  initial begin
    int ack;
    ack = 0;
    bus.op_complete = 1'b0;
    forever begin
      @(negedge clk50);
      if (resp_en && (bus.set_measure || bus.set_vos || bus.set_gain)) begin
        if (ack >= 10) bus.op_complete = 1'b1;
        else           ack++;
      end else begin
        ack = 0;
        bus.op_complete = 1'b0;
      end
    end
  end

  // Command log, strobe exclusivity and done pulse monitor
  initial begin
    logic pm, pv, pg;
    pm = 1'b0; pv = 1'b0; pg = 1'b0;
    forever begin
      @(negedge clk50);
      if (bus.set_measure && !pm) ev.push_back({3'b001, 5'd0});
      if (bus.set_vos && !pv)     ev.push_back({3'b010, bus.offset});
      if (bus.set_gain && !pg)    ev.push_back({3'b100, 1'b0, bus.gain});
      if ((32'(bus.set_measure) + 32'(bus.set_vos) + 32'(bus.set_gain)) > 1) multi_hot++;
      if (done) done_cnt++;
      pm = bus.set_measure;
      pv = bus.set_vos;
      pg = bus.set_gain;
    end
  end

  function automatic logic [63:0] log_sig();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = {s[55:0], (i < ev.size()) ? ev[i] : 8'h00};
    return s;
  endfunction

  task automatic start_pulse(input logic [3:0] g);
    @(negedge clk50);
    start = 1'b1;
    gain_in = g;
    @(negedge clk50);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50);
      if (done || (error && !busy)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    ev.delete();
    done_cnt = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [19:0] outs;
    wb_rst = 1'b1;
    repeat (3) @(negedge clk50);
    outs = {bus.set_measure, bus.set_vos, bus.set_gain, bus.offset, bus.gain,
            busy, done, error, cal_offset};
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 00000", outs);
    end
    wb_rst = 1'b0;
    repeat (5) @(negedge clk50);
    checks++;
    if ({busy, done, error} !== 3'b000 || ev.size() !== 0) begin
      errors++;
      $display("FAIL reset_idle busy/done/error %b events %0d want 000 and 0",
               {busy, done, error}, ev.size());
    end
  endtask

  task automatic run_and_check(input string name, input int mode, input logic [3:0] g,
                               input logic [63:0] sig, input logic [4:0] cal,
                               input bit poke_start);
    bit ok;
    cmp_mode = mode;
    clear_log();
    start_pulse(g);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_after_start got %b want 1", name, busy);
    end
    if (poke_start) begin
      repeat (60) @(negedge clk50);
      start_pulse(4'h3);
    end
    wait_end(5000, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_completion no done within 5000 cycles", name);
    end
    checks++;
    if (cal_offset !== cal) begin
      errors++;
      $display("FAIL %s_cal_offset got %0d want %0d", name, cal_offset, cal);
    end
    repeat (20) @(negedge clk50);
    checks++;
    if (ev.size() !== 8 || log_sig() !== sig) begin
      errors++;
      $display("FAIL %s_commands count %0d sig %h want 8 and %h", name, ev.size(), log_sig(), sig);
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || error !== 1'b0 || cal_offset !== cal) begin
      errors++;
      $display("FAIL %s_end done_pulses %0d busy %b error %b cal %0d want 1 0 0 %0d",
               name, done_cnt, busy, error, cal_offset, cal);
    end
  endtask

  task automatic test_nominal();
    run_and_check("nominal", 0, 4'h9, 64'h2050_5854_5253_5389, 5'd19, 1'b0);
    checks++;
    if (multi_hot !== 0) begin
      errors++;
      $display("FAIL strobe_exclusive overlapping cycles %0d want 0", multi_hot);
    end
  endtask

  task automatic test_tied_high();
    run_and_check("tied_high", 1, 4'h5, 64'h2050_585C_5E5F_5F85, 5'd31, 1'b0);
  endtask

  task automatic test_tied_low();
    run_and_check("tied_low", 2, 4'hA, 64'h2050_4844_4241_408A, 5'd0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_and_check("start_busy", 0, 4'h9, 64'h2050_5854_5253_5389, 5'd19, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] outs;
    int          n;
    bit          seen;
    cmp_mode = 0;
    clear_log();
    start_pulse(4'h9);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk50);
      if (ev.size() >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL midrst_third_trial not reached within 2000 cycles");
    end
    repeat (100) @(negedge clk50);   // inside third trial's settle window
    wb_rst = 1'b1;
    #1;
    outs = {bus.set_measure, bus.set_vos, bus.set_gain, bus.offset, bus.gain,
            busy, done, error, cal_offset};
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 00000", outs);
    end
    n = ev.size();
    repeat (3) @(negedge clk50);
    wb_rst = 1'b0;
    repeat (10) @(negedge clk50);
    checks++;
    if (ev.size() !== n || busy !== 1'b0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_abort events %0d busy %b done %0d want %0d 0 0",
               ev.size(), busy, done_cnt, n);
    end
    run_and_check("after_rst", 0, 4'h9, 64'h2050_5854_5253_5389, 5'd19, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef PGA_AUTOCAL_TIMEOUT_EN
    int hi;
    bit ok;
    cmp_mode = 0;
    resp_en = 1'b0;
    clear_log();
    start_pulse(4'h2);
    hi = 0;
    for (int i = 0; i < 6000; i++) begin
      if (bus.set_measure) hi++;
      else if (hi > 0) break;
      @(negedge clk50);
    end
    checks++;
    if (hi !== 4096) begin
      errors++;
      $display("FAIL timeout_hold set_measure high %0d cycles want 4096", hi);
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags error %b busy %b want 1 0", error, busy);
    end
    repeat (5) @(negedge clk50);
    checks++;
    if (done_cnt !== 0 || error !== 1'b1 || ev.size() !== 1) begin
      errors++;
      $display("FAIL timeout_sticky done %0d error %b events %0d want 0 1 1",
               done_cnt, error, ev.size());
    end
    resp_en = 1'b1;
    clear_log();
    start_pulse(4'h9);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear error %b busy %b want 0 1", error, busy);
    end
    wait_end(5000, ok);
    checks++;
    if (ok !== 1'b1 || cal_offset !== 5'd19) begin
      errors++;
      $display("FAIL timeout_recover ok %b cal %0d want 1 19", ok, cal_offset);
    end
`else
    resp_en = 1'b0;
    clear_log();
    start_pulse(4'h2);
    repeat (5000) @(negedge clk50);
    checks++;
    if (bus.set_measure !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL unbounded_wait set_measure %b busy %b error %b want 1 1 0",
               bus.set_measure, busy, error);
    end
    wb_rst = 1'b1;
    @(negedge clk50);
    wb_rst = 1'b0;
    resp_en = 1'b1;
    repeat (5) @(negedge clk50);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL unbounded_abort busy %b error %b want 0 0", busy, error);
    end
`endif
  endtask

  // -------------------------------------------------------------------------
  initial begin
    wb_rst  = 1'b1;
    start   = 1'b0;
    gain_in = 4'h0;
    test_reset();
    test_nominal();
    test_tied_high();
    test_tied_low();
    test_start_while_busy();
    test_reset_mid_run();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
